effect_frame_sequencer: RTL and testbench

- Initiator side of the effect START/DONE frame handshake.
- Takes 16-bit audio samples from the codec receiver and buffers them in a small FIFO.
- Issues one-cycle START pulses to an effect block, waits for its DONE pulse, then forwards the processed frame to the DAC path.
- A timeout falls back to passthrough so a hung or absent effect never stalls the audio stream.

---
 rtl/fx_seq_pkg.sv | 19 +
 rtl/frame_fifo.sv | 56 +++++
 rtl/effect_frame_sequencer.sv | 132 +++++++++++++
 tb/tb_effect_frame_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_seq_pkg.sv
// Shared types and constants for the effect frame sequencer.
package fx_seq_pkg;

  localparam int FRAME_W = 16;
  localparam int STAT_W  = 8;

  typedef logic signed [FRAME_W-1:0] frame_t;

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } seq_state_t;

  // Statistics counters hold at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Circular sample FIFO; DEPTH must be a power of two so the pointers wrap for free.
module frame_fifo
  import fx_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  frame_t                   push_data,
  input  logic                     pop,
  output frame_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  frame_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/effect_frame_sequencer.sv
// START/DONE initiator: buffers codec samples, runs each through an effect with timeout fallback.
// Define SEQ_STATS_EN to build the saturating overrun/timeout counters.
module effect_frame_sequencer
  import fx_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               adc_valid,
  input  logic [FRAME_W-1:0] adc_frame,
  input  logic               bypass,
  output logic               FX_START,
  output logic [FRAME_W-1:0] fx_input_frame,
  input  logic               FX_DONE,
  input  logic [FRAME_W-1:0] fx_output_frame,
  output logic               dac_valid,
  output logic [FRAME_W-1:0] dac_frame,
  output logic               overrun,
  output logic               fx_timeout,
  output logic [STAT_W-1:0]  overrun_count,
  output logic [STAT_W-1:0]  timeout_count
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [AW:0]       FIFO_FULL = (AW+1)'(DEPTH);
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  frame_t            fx_input_frame_q, dac_frame_q;
  logic              fx_start_q, dac_valid_q, overrun_q, fx_timeout_q;

  frame_t            fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]       fifo_count;

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (adc_valid),
    .push_data (frame_t'(adc_frame)),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= IDLE;
      wait_cnt_q       <= '0;
      fx_input_frame_q <= '0;
      dac_frame_q      <= '0;
      fx_start_q       <= 1'b0;
      dac_valid_q      <= 1'b0;
      overrun_q        <= 1'b0;
      fx_timeout_q     <= 1'b0;
    end else begin
      fx_start_q   <= 1'b0;
      dac_valid_q  <= 1'b0;
      fx_timeout_q <= 1'b0;
      overrun_q    <= adc_valid && fifo_full && !fifo_pop;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (bypass) begin
              dac_frame_q <= fifo_head;
              dac_valid_q <= 1'b1;
            end else begin
              fx_input_frame_q <= fifo_head;
              fx_start_q       <= 1'b1;
              wait_cnt_q       <= '0;
              state_q          <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          // DONE takes priority over a timeout expiring in the same cycle.
          if (FX_DONE) begin
            dac_frame_q <= frame_t'(fx_output_frame);
            dac_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            dac_frame_q  <= fx_input_frame_q;
            dac_valid_q  <= 1'b1;
            fx_timeout_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FX_START       = fx_start_q;
  assign fx_input_frame = fx_input_frame_q;
  assign dac_valid      = dac_valid_q;
  assign dac_frame      = dac_frame_q;
  assign overrun        = overrun_q;
  assign fx_timeout     = fx_timeout_q;

`ifdef SEQ_STATS_EN
  logic [STAT_W-1:0] overrun_count_q, timeout_count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      overrun_count_q <= '0;
      timeout_count_q <= '0;
    end else begin
      if (overrun_q)    overrun_count_q <= sat_inc(overrun_count_q);
      if (fx_timeout_q) timeout_count_q <= sat_inc(timeout_count_q);
    end
  end

  assign overrun_count = overrun_count_q;
  assign timeout_count = timeout_count_q;
`else
  assign overrun_count = '0;
  assign timeout_count = '0;
`endif

  assert property (@(posedge CLK) disable iff (RESET) fifo_count <= FIFO_FULL);

endmodule

// File: tb/tb_effect_frame_sequencer.sv
// Scoreboard bench for effect_frame_sequencer; expectations follow SEQ_STATS_EN when defined.
module tb_effect_frame_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
`ifdef SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_frame = '0;
  logic        bypass = 1'b0;
  logic        FX_START;
  logic [15:0] fx_input_frame;
  logic        FX_DONE = 1'b0;
  logic [15:0] fx_output_frame = '0;
  logic        dac_valid;
  logic [15:0] dac_frame;
  logic        overrun;
  logic        fx_timeout;
  logic [7:0]  overrun_count;
  logic [7:0]  timeout_count;

  typedef struct packed {
    logic [15:0] frame;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          start_cnt = 0;
  int          ovr_cnt = 0;
  int          resp_mode = 0;   // 0 silent, 1 constant reply, 2 inverted input
  logic [15:0] resp_val = '0;
  logic        inject_done = 1'b0;
  logic [15:0] inject_val = '0;

  effect_frame_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .adc_valid       (adc_valid),
    .adc_frame       (adc_frame),
    .bypass          (bypass),
    .FX_START        (FX_START),
    .fx_input_frame  (fx_input_frame),
    .FX_DONE         (FX_DONE),
    .fx_output_frame (fx_output_frame),
    .dac_valid       (dac_valid),
    .dac_frame       (dac_frame),
    .overrun         (overrun),
    .fx_timeout      (fx_timeout),
    .overrun_count   (overrun_count),
    .timeout_count   (timeout_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  // Effect responder model: replies in the cycle after START.
  always @(posedge CLK) begin
    if (inject_done) begin
      FX_DONE         <= 1'b1;
      fx_output_frame <= inject_val;
    end else if (resp_mode == 1 && FX_START) begin
      FX_DONE         <= 1'b1;
      fx_output_frame <= resp_val;
    end else if (resp_mode == 2 && FX_START) begin
      FX_DONE         <= 1'b1;
      fx_output_frame <= ~fx_input_frame;
    end else begin
      FX_DONE <= 1'b0;
    end
  end

  // Output monitor: every dac_valid pops one expected frame.
  always @(negedge CLK) begin
    exp_t e;
    if (FX_START) start_cnt++;
    if (overrun)  ovr_cnt++;
    if (!RESET && dac_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_dac: got frame %h tmo %b, required no dac_valid", dac_frame, fx_timeout);
      end else begin
        e = sb_q.pop_front();
        if (dac_frame !== e.frame || fx_timeout !== e.tmo) begin
          n_mis++;
          $display("FAIL dac_output: got frame %h tmo %b, required frame %h tmo %b",
                   dac_frame, fx_timeout, e.frame, e.tmo);
        end
      end
    end else if (!RESET && fx_timeout) begin
      n_cmp++;
      n_mis++;
      $display("FAIL stray_timeout: got fx_timeout 1 without dac_valid, required 0");
    end
  end

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && sb_q.size() != 0; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (FX_START !== 1'b0 || dac_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_strobes: got start %b dac_valid %b, required 0 0", FX_START, dac_valid);
    end
    n_cmp++;
    if (fx_input_frame !== 16'h0 || dac_frame !== 16'h0) begin
      n_mis++;
      $display("FAIL reset_frames: got fx_in %h dac %h, required 0000 0000", fx_input_frame, dac_frame);
    end
    n_cmp++;
    if (overrun !== 1'b0 || fx_timeout !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_pulses: got overrun %b timeout %b, required 0 0", overrun, fx_timeout);
    end
    n_cmp++;
    if (overrun_count !== 8'h0 || timeout_count !== 8'h0) begin
      n_mis++;
      $display("FAIL reset_counts: got %h %h, required 00 00", overrun_count, timeout_count);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_effect;
    resp_mode = 1;
    resp_val  = 16'h3fff;
    start_cnt = 0;
    adc_valid = 1'b1;
    adc_frame = 16'h5000;
    sb_q.push_back('{frame: 16'h3fff, tmo: 1'b0});
    @(negedge CLK);               // after edge t
    adc_valid = 1'b0;
    n_cmp++;
    if (FX_START !== 1'b0) begin
      n_mis++;
      $display("FAIL effect_start_early: got %b at t, required 0", FX_START);
    end
    @(negedge CLK);               // after t+1
    n_cmp++;
    if (FX_START !== 1'b1 || fx_input_frame !== 16'h5000) begin
      n_mis++;
      $display("FAIL effect_start: got start %b fx_in %h, required 1 5000", FX_START, fx_input_frame);
    end
    @(negedge CLK);               // after t+2
    n_cmp++;
    if (FX_START !== 1'b0 || fx_input_frame !== 16'h5000 || dac_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL effect_wait: got start %b fx_in %h dac_valid %b, required 0 5000 0",
               FX_START, fx_input_frame, dac_valid);
    end
    @(negedge CLK);               // after t+3
    n_cmp++;
    if (dac_valid !== 1'b1 || dac_frame !== 16'h3fff) begin
      n_mis++;
      $display("FAIL effect_dac: got valid %b frame %h, required 1 3fff", dac_valid, dac_frame);
    end
    @(negedge CLK);
    n_cmp++;
    if (dac_valid !== 1'b0 || dac_frame !== 16'h3fff || start_cnt != 1) begin
      n_mis++;
      $display("FAIL effect_after: got valid %b frame %h starts %0d, required 0 3fff 1",
               dac_valid, dac_frame, start_cnt);
    end
    resp_mode = 0;
  endtask

  task automatic test_timeout;
    int s_at = -1;
    int t_at = -1;
    resp_mode = 0;
    start_cnt = 0;
    adc_valid = 1'b1;
    adc_frame = 16'h1234;
    sb_q.push_back('{frame: 16'h1234, tmo: 1'b1});
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      adc_valid = 1'b0;
      if (FX_START && s_at < 0) s_at = i;
      if (fx_timeout && t_at < 0) t_at = i;
    end
    n_cmp++;
    if (s_at < 0 || t_at < 0 || (t_at - s_at) != TMO) begin
      n_mis++;
      $display("FAIL timeout_latency: got start@%0d timeout@%0d, required distance %0d", s_at, t_at, TMO);
    end
    n_cmp++;
    if (start_cnt != 1 || sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL timeout_single_start: got starts %0d pending %0d, required 1 0", start_cnt, sb_q.size());
    end
  endtask

  task automatic test_overrun;
    resp_mode = 0;
    ovr_cnt   = 0;
    for (int i = 1; i <= 6; i++) begin
      adc_valid = 1'b1;
      adc_frame = 16'(i);
      if (i <= 5) sb_q.push_back('{frame: 16'(i), tmo: 1'b1});
      @(negedge CLK);
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_mis++;
      $display("FAIL overrun_pulse: got %b after sixth push, required 1", overrun);
    end
    wait_drain(5 * (TMO + 4) + 10);
    n_cmp++;
    if (sb_q.size() != 0 || ovr_cnt != 1) begin
      n_mis++;
      $display("FAIL overrun_drain: got pending %0d overruns %0d, required 0 1", sb_q.size(), ovr_cnt);
      sb_q.delete();
    end
    n_cmp++;
    if (overrun_count !== (STATS ? 8'd1 : 8'd0) || timeout_count !== (STATS ? 8'd6 : 8'd0)) begin
      n_mis++;
      $display("FAIL overrun_stats: got ovr %0d tmo %0d, required %0d %0d",
               overrun_count, timeout_count, STATS ? 1 : 0, STATS ? 6 : 0);
    end
  endtask

  task automatic test_bypass;
    bypass    = 1'b1;
    start_cnt = 0;
    adc_valid = 1'b1;
    adc_frame = 16'h8000;
    sb_q.push_back('{frame: 16'h8000, tmo: 1'b0});
    @(negedge CLK);
    adc_frame = 16'h7fff;
    sb_q.push_back('{frame: 16'h7fff, tmo: 1'b0});
    @(negedge CLK);
    adc_valid = 1'b0;
    n_cmp++;
    if (dac_valid !== 1'b1 || dac_frame !== 16'h8000) begin
      n_mis++;
      $display("FAIL bypass_first: got valid %b frame %h, required 1 8000", dac_valid, dac_frame);
    end
    @(negedge CLK);
    n_cmp++;
    if (dac_valid !== 1'b1 || dac_frame !== 16'h7fff) begin
      n_mis++;
      $display("FAIL bypass_second: got valid %b frame %h, required 1 7fff", dac_valid, dac_frame);
    end
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (dac_valid !== 1'b0 || start_cnt != 0) begin
      n_mis++;
      $display("FAIL bypass_quiet: got valid %b starts %0d, required 0 0", dac_valid, start_cnt);
    end
    bypass = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [4];
    int last = -1;
    int seen = 0;
    bit gap_ok = 1'b1;
    vals[0] = 16'ha5a5; vals[1] = 16'h0f0f; vals[2] = 16'h8001; vals[3] = 16'h7ffe;
    resp_mode = 2;
    ovr_cnt   = 0;
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_frame = vals[i];
      sb_q.push_back('{frame: ~vals[i], tmo: 1'b0});
      @(negedge CLK);
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dac_valid) begin
        if (last >= 0 && (i - last) != 3) gap_ok = 1'b0;
        last = i;
        seen++;
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (seen != 4 || !gap_ok || sb_q.size() != 0 || ovr_cnt != 0) begin
      n_mis++;
      $display("FAIL b2b_throughput: got frames %0d spacing_ok %b pending %0d overruns %0d, required 4 1 0 0",
               seen, gap_ok, sb_q.size(), ovr_cnt);
      sb_q.delete();
    end
    resp_mode = 0;
  endtask

  task automatic test_reset_mid_wait;
    int late_valid = 0;
    resp_mode = 0;
    adc_valid = 1'b1;
    adc_frame = 16'h4242;
    @(negedge CLK);
    adc_valid = 1'b0;
    repeat (3) @(negedge CLK);    // well inside WAIT_DONE
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_cmp++;
    if (FX_START !== 1'b0 || fx_input_frame !== 16'h0 || dac_valid !== 1'b0 || dac_frame !== 16'h0) begin
      n_mis++;
      $display("FAIL midreset_outputs: got start %b fx_in %h valid %b dac %h, required 0 0000 0 0000",
               FX_START, fx_input_frame, dac_valid, dac_frame);
    end
    n_cmp++;
    if (overrun_count !== 8'h0 || timeout_count !== 8'h0) begin
      n_mis++;
      $display("FAIL midreset_counts: got %h %h, required 00 00", overrun_count, timeout_count);
    end
    inject_done = 1'b1;
    inject_val  = 16'hdead;
    @(negedge CLK);
    inject_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (dac_valid) late_valid++;
    end
    n_cmp++;
    if (late_valid != 0 || dac_frame !== 16'h0) begin
      n_mis++;
      $display("FAIL midreset_late_done: got %0d dac_valid frame %h, required 0 0000", late_valid, dac_frame);
    end
    resp_mode = 1;
    resp_val  = 16'h1357;
    adc_valid = 1'b1;
    adc_frame = 16'h0abc;
    sb_q.push_back('{frame: 16'h1357, tmo: 1'b0});
    @(negedge CLK);
    adc_valid = 1'b0;
    wait_drain(20);
    n_cmp++;
    if (sb_q.size() != 0 || fx_input_frame !== 16'h0abc) begin
      n_mis++;
      $display("FAIL midreset_recover: got pending %0d fx_in %h, required 0 0abc", sb_q.size(), fx_input_frame);
      sb_q.delete();
    end
    resp_mode = 0;
  endtask

  task automatic test_stats;
    int stalled = 0;
    resp_mode = 0;
    for (int i = 0; i < 300; i++) begin
      adc_valid = 1'b1;
      adc_frame = 16'(i * 7 + 3);
      sb_q.push_back('{frame: 16'(i * 7 + 3), tmo: 1'b1});
      @(negedge CLK);
      adc_valid = 1'b0;
      for (int k = 0; k < TMO + 10 && sb_q.size() != 0; k++) @(negedge CLK);
      if (sb_q.size() != 0) begin
        stalled++;
        sb_q.delete();
      end
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (stalled != 0) begin
      n_mis++;
      $display("FAIL stats_stream: got %0d stalled timeouts, required 0", stalled);
    end
    n_cmp++;
    if (timeout_count !== (STATS ? 8'hff : 8'h00) || overrun_count !== 8'h00) begin
      n_mis++;
      $display("FAIL stats_saturate: got tmo %h ovr %h, required %h 00",
               timeout_count, overrun_count, STATS ? 8'hff : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_effect();
    test_timeout();
    test_overrun();
    test_bypass();
    test_back_to_back();
    test_reset_mid_wait();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
